// File: rtl/spi_rx_fifo.sv
// Receive FIFO behind the SPI slave: synchronizes done_in, captures one din word per done pulse.
// Optional macro SPI_RX_DROP_CNT_EN adds an 8-bit saturating drop counter output.
module spi_rx_fifo #(
    parameter int DATA_W      = 12,
    parameter int DEPTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     done_in,
    input  logic [DATA_W-1:0]        din,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow,
    input  logic                     clr_ovf
`ifdef SPI_RX_DROP_CNT_EN
    ,
    output logic [7:0]               drop_cnt
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, WRITE, WAIT_LOW} state_t;

    state_t                 state, state_next;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] primed_q;
    logic                   done_s, done_d, rise, primed;
    logic                   push, pop, accept, drop;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [AW-1:0]          wr_ptr, rd_ptr;
    logic [CW-1:0]          count_next;

    assign done_s = sync_q[SYNC_STAGES-1];
    assign primed = primed_q[SYNC_STAGES-1];
    assign rise   = done_s & ~done_d;

    // primed_q marks when done_s reflects real samples, so a done held high through reset is not mistaken for a fresh rise
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q   <= '0;
            primed_q <= '0;
            done_d   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], done_in};
            primed_q <= {primed_q[SYNC_STAGES-2:0], 1'b1};
            done_d   <= done_s;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT_LOW;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:     if (rise) state_next = WRITE;
            WRITE:    state_next = WAIT_LOW;
            WAIT_LOW: if (primed && !done_s) state_next = IDLE;
            default:  state_next = WAIT_LOW;
        endcase
    end

    always_comb begin
        push = (state == WRITE);
    end

    assign m_valid = ~empty;
    assign m_data  = empty ? '0 : mem[rd_ptr];
    assign pop     = m_valid & m_ready;
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;

    always_comb begin
        count_next = count;
        if (accept && !pop)      count_next = count + CW'(1);
        else if (!accept && pop) count_next = count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop)    rd_ptr <= rd_ptr + AW'(1);
            count <= count_next;
            full  <= (count_next == CW'(DEPTH));
            empty <= (count_next == '0);
        end
    end

    // a drop in the same cycle as clr_ovf keeps the flag set
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)         overflow <= 1'b0;
        else if (drop)    overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

`ifdef SPI_RX_DROP_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                          drop_cnt <= 8'd0;
        else if (clr_ovf)                  drop_cnt <= drop ? 8'd1 : 8'd0;
        else if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
`endif

endmodule

// File: tb/tb_spi_rx_fifo.sv
// Scoreboard bench for spi_rx_fifo: frames push expected words, a negedge monitor checks every pop.
`timescale 1ns/1ps
module tb_spi_rx_fifo;

    logic        clk = 1'b0;
    logic        rst;
    logic        done_in;
    logic [11:0] din;
    logic        m_valid;
    logic        m_ready;
    logic [11:0] m_data;
    logic [3:0]  count;
    logic        full, empty, overflow;
    logic        clr_ovf;
`ifdef SPI_RX_DROP_CNT_EN
    logic [7:0]  drop_cnt;
`endif

    int          checks = 0;
    int          errors = 0;
    logic [11:0] exp_q[$];

    spi_rx_fifo dut (
        .clk      (clk),
        .rst      (rst),
        .done_in  (done_in),
        .din      (din),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .count    (count),
        .full     (full),
        .empty    (empty),
        .overflow (overflow),
        .clr_ovf  (clr_ovf)
`ifdef SPI_RX_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // mode 1 raises m_ready and mode 2 raises clr_ovf during the WRITE cycle (between edges 2 and 3 after sampling)
    task automatic apply_stimulus(input logic [11:0] word, input int high_len, input int mode,
                                  input bit expect_push, input bit check_lat);
        @(negedge clk);
        din     = word;
        done_in = 1'b1;
        if (expect_push) exp_q.push_back(word);
        for (int e = 0; e < high_len; e++) begin
            @(posedge clk);
            #1;
            if (e == 2 && mode == 1) m_ready = 1'b1;
            if (e == 2 && mode == 2) clr_ovf = 1'b1;
            if (e == 3 && mode == 1) m_ready = 1'b0;
            if (e == 3 && mode == 2) clr_ovf = 1'b0;
            if (check_lat && e == 2) check_output("latency_m_valid_edge3", m_valid, 1'b0);
            if (check_lat && e == 3) check_output("latency_m_valid_edge4", m_valid, 1'b1);
        end
        done_in = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic drain_all();
        int n = 0;
        m_ready = 1'b1;
        while (!empty && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        m_ready = 1'b0;
        check_output("drain_empty", empty, 1'b1);
        check_output("drain_count", count, 4'd0);
        check_output("drain_scoreboard", exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst && m_valid && m_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_pop: got %0h, expected no word", m_data);
            end else begin
                check_output("pop_data", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        done_in = 1'b0;
        din     = '0;
        m_ready = 1'b0;
        clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_output("reset_m_valid", m_valid, 1'b0);
        check_output("reset_empty", empty, 1'b1);
        check_output("reset_full", full, 1'b0);
        check_output("reset_overflow", overflow, 1'b0);
        check_output("reset_count", count, 4'd0);
        check_output("reset_m_data", m_data, 12'h000);
`ifdef SPI_RX_DROP_CNT_EN
        check_output("reset_drop_cnt", drop_cnt, 8'd0);
`endif
        @(negedge clk);
        rst = 1'b1;
        repeat (4) @(posedge clk);
        #1;

        $display("[TB] single frame");
        apply_stimulus(12'hA5C, 22, 0, 1'b1, 1'b1);
        check_output("single_count", count, 4'd1);
        check_output("single_head", m_data, 12'hA5C);
        m_ready = 1'b1;
        @(posedge clk);
        #1;
        m_ready = 1'b0;
        check_output("single_empty", empty, 1'b1);
        check_output("single_count_after_pop", count, 4'd0);

        $display("[TB] fill and overflow");
        for (int i = 1; i <= 8; i++) apply_stimulus(12'(i), 22, 0, 1'b1, 1'b0);
        check_output("fill_full", full, 1'b1);
        check_output("fill_count", count, 4'd8);
        apply_stimulus(12'hFFF, 22, 0, 1'b0, 1'b0);
        check_output("ovf_flag", overflow, 1'b1);
        check_output("ovf_count", count, 4'd8);
`ifdef SPI_RX_DROP_CNT_EN
        check_output("ovf_drop_cnt", drop_cnt, 8'd1);
`endif
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check_output("ovf_cleared", overflow, 1'b0);

        $display("[TB] push while full with pop");
        apply_stimulus(12'h123, 22, 1, 1'b1, 1'b0);
        check_output("full_pop_count", count, 4'd8);
        check_output("full_pop_overflow", overflow, 1'b0);
        drain_all();

        $display("[TB] done held through reset");
        @(negedge clk);
        rst     = 1'b0;
        done_in = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        check_output("held_done_count", count, 4'd0);
        check_output("held_done_empty", empty, 1'b1);
        done_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        apply_stimulus(12'h3C3, 22, 0, 1'b1, 1'b0);
        check_output("after_held_count", count, 4'd1);
        drain_all();

        $display("[TB] long done");
        apply_stimulus(12'h7E7, 100, 0, 1'b1, 1'b0);
        check_output("long_done_count", count, 4'd1);

        $display("[TB] clr_ovf against drop");
        for (int i = 0; i < 7; i++) apply_stimulus(12'h010 + 12'(i), 22, 0, 1'b1, 1'b0);
        check_output("refill_full", full, 1'b1);
        apply_stimulus(12'hBAD, 22, 2, 1'b0, 1'b0);
        check_output("clr_vs_drop_overflow", overflow, 1'b1);
        check_output("clr_vs_drop_count", count, 4'd8);
`ifdef SPI_RX_DROP_CNT_EN
        check_output("clr_vs_drop_cnt", drop_cnt, 8'd1);
`endif
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        check_output("clr_alone_overflow", overflow, 1'b0);
`ifdef SPI_RX_DROP_CNT_EN
        check_output("clr_alone_drop_cnt", drop_cnt, 8'd0);
`endif
        drain_all();

        repeat (4) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
